fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Round-robin, burst-capable write-port arbiter in front of the write side of the async FIFO. It shares a single FIFO write port between N_REQ independent producers in the write clock domain, using per-requester valid/ready handshakes. Each grant holds for a burst of up to BURST_MAX beats. Writes are throttled from the FIFO's full/almost-full flags so the FIFO never silently drops a beat.

## Interface
- N_REQ, 4, number of requesters (≥2)
- WIDTH, 8, data width per beat
- BURST_MAX, 4, max beats per grant (≥1)
- SRC_W, $clog2(N_REQ), source-index width (localparam)

- i_wr_clk  in  1  write-domain clock; all logic on rising edge
- i_wr_rstn  in  1  asynchronous, active-low reset
- i_req_valid  in  N_REQ  per-requester beat valid
- i_req_data  in  N_REQ*WIDTH  requester k data at [k*WIDTH +: WIDTH]
- o_req_ready  out  N_REQ  per-requester accept (combinational)
- i_fifo_full  in  1  FIFO o_wr_full
- i_fifo_afull  in  1  FIFO o_wr_afull (exactly one free slot or fewer)
- o_fifo_wr_en  out  1  registered FIFO write strobe
- o_fifo_wr_data  out  WIDTH  registered FIFO write data
- o_fifo_wr_src  out  SRC_W  index of the requester owning the current o_fifo_wr_data
- o_grant  out  N_REQ  registered one-hot grant, all zeros in IDLE
- o_busy  out  1  high in BURST

## Operation
- States: IDLE, BURST. rr_ptr (SRC_W bits) marks the highest-priority requester; beat_cnt counts 0..BURST_MAX-1.
- IDLE: if |i_req_valid, pick the first set bit scanning rr_ptr, rr_ptr+1, … (mod N_REQ). Register the one-hot grant, clear beat_cnt, go to BURST. No beat is accepted in IDLE.
- space = !i_fifo_full && !(o_fifo_wr_en && i_fifo_afull). This accounts for the write already in flight in the output register.
- BURST: o_req_ready = o_grant & {N_REQ{space}}. A beat is accepted when the granted requester has valid && ready. The beat is registered to o_fifo_wr_data/o_fifo_wr_src, o_fifo_wr_en=1 next cycle, and beat_cnt increments.
- Burst ends, returning to IDLE next cycle with o_grant cleared and rr_ptr = granted index + 1 mod N_REQ, when either:
  - a beat is accepted with beat_cnt == BURST_MAX-1, or
  - the granted i_req_valid is low in any BURST cycle.
- Stall (space=0) with granted valid high: hold the grant, do not count, do not release.
- o_fifo_wr_en deasserts on every cycle without an accepted beat. Data/src hold their last value.
- Non-granted requesters always see ready=0.

## Timing
- Reset: state=IDLE, rr_ptr=0, beat_cnt=0, all outputs 0.
- Reset mid-burst: clears immediately. A beat accepted in the cycle before reset assertion and not yet written is discarded.
- Arbitration latency: 1 cycle (valid in IDLE at cycle t → grant/ready at t+1).
- Write latency: accepted beat at cycle t → o_fifo_wr_en at t+1.
- Back-to-back: sustained 1 beat/cycle within a burst. One idle cycle (IDLE) separates consecutive bursts.
- Full boundary: with afull high and a write in flight, ready drops the same cycle, so zero beats are dropped by the FIFO.
- wrap: rr_ptr wraps N_REQ-1 → 0.
- BURST_MAX=1: each accepted beat ends the grant.

## Structure
- Package fifo_arb_pkg: state enum (IDLE, BURST), and a function computing the SRC_W width for a given N_REQ.
- Sub-module rr_picker (combinational): inputs i_req, i_ptr; output one-hot o_gnt plus o_idx. This sub-module is reused for read-side scheduling.
- Top owns the FSM, beat_cnt, space logic and the output register.

## Test plan
- Single requester 0, 6 beats continuous, BURST_MAX=4 → beats 0-3 written on consecutive cycles, 1 IDLE cycle, beats 4-5 written, o_fifo_wr_src=0 throughout, rr_ptr=1 at end.
- All 4 requesters valid continuously → grant order 0,1,2,3,0, 4 beats each. Output data order matches per-requester sequences.
- Requester 2 drops valid after 2 beats → release next cycle, rr_ptr=3, requester 3 granted.
- i_fifo_afull=1 with a write in flight → o_req_ready=0 that cycle. Raise i_fifo_full for 5 cycles → no o_fifo_wr_en, grant held, no beat lost or duplicated; resumes on deassert.
- Reset asserted mid-burst (beat_cnt=2) → all outputs 0 asynchronously, IDLE after release, first grant goes to lowest valid index ≥0.
- Random valid/full stress, 10k cycles → scoreboard: every accepted beat written exactly once, in order per requester, no write while i_fifo_full.

Source files
------------

// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter and its picker.
package fifo_arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    // Index width for n items; never narrower than one bit so n == 1 stays legal.
    function automatic int src_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester/FIFO-side bundle of the write-port arbiter.
// slave = arbiter view, master = producers plus FIFO flags.
interface fifo_wr_arbiter_if
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8
);
    localparam int SRC_W = src_width(N_REQ);

    logic [N_REQ-1:0]       i_req_valid;
    logic [N_REQ*WIDTH-1:0] i_req_data;
    logic [N_REQ-1:0]       o_req_ready;
    logic                   i_fifo_full;
    logic                   i_fifo_afull;
    logic                   o_fifo_wr_en;
    logic [WIDTH-1:0]       o_fifo_wr_data;
    logic [SRC_W-1:0]       o_fifo_wr_src;
    logic [N_REQ-1:0]       o_grant;
    logic                   o_busy;

    modport slave (
        input  i_req_valid, i_req_data, i_fifo_full, i_fifo_afull,
        output o_req_ready, o_fifo_wr_en, o_fifo_wr_data, o_fifo_wr_src, o_grant, o_busy
    );

    modport master (
        output i_req_valid, i_req_data, i_fifo_full, i_fifo_afull,
        input  o_req_ready, o_fifo_wr_en, o_fifo_wr_data, o_fifo_wr_src, o_grant, o_busy
    );

endinterface

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request scanning from i_ptr
// upward with wrap. Also used by the read-side scheduler.
module rr_picker
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int SRC_W = src_width(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [SRC_W-1:0] i_ptr,
    output logic [N_REQ-1:0] o_gnt,
    output logic [SRC_W-1:0] o_idx
);

    logic found;
    int   cand;

    // Scan N_REQ positions starting at i_ptr; the first hit wins.
    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        found = 1'b0;
        cand  = 0;
        for (int off = 0; off < N_REQ; off++) begin
            cand = (int'(i_ptr) + off) % N_REQ;
            if (!found && i_req[cand[SRC_W-1:0]]) begin
                found                    = 1'b1;
                o_gnt[cand[SRC_W-1:0]]   = 1'b1;
                o_idx                    = cand[SRC_W-1:0];
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port between N_REQ producers.
//
// state | meaning
// IDLE  | no owner; next owner picked round-robin from rr_ptr, no beat accepted
// BURST | o_grant owner pushes up to BURST_MAX beats, throttled by FIFO space
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int WIDTH     = 8,
    parameter int BURST_MAX = 4
) (
    input  logic             i_wr_clk,
    input  logic             i_wr_rstn,
    fifo_wr_arbiter_if.slave bus
);

    localparam int SRC_W = src_width(N_REQ);
    localparam int CNT_W = src_width(BURST_MAX);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_MAX - 1);
    localparam logic [SRC_W-1:0] IDX_LAST = SRC_W'(N_REQ - 1);

    arb_state_e       state_q, state_d;
    logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [SRC_W-1:0] gnt_idx_q, gnt_idx_d;
    logic             wr_en_q, wr_en_d;
    logic [WIDTH-1:0] wr_data_q, wr_data_d;
    logic [SRC_W-1:0] wr_src_q, wr_src_d;

    logic [N_REQ-1:0] pick_gnt;
    logic [SRC_W-1:0] pick_idx;
    logic             any_req;
    logic             space;
    logic             gnt_valid;
    logic             accept;
    logic             last_beat;
    logic             release_burst;
    logic [WIDTH-1:0] beat_data;
    logic [N_REQ-1:0] req_ready;
    logic             busy;

    rr_picker #(
        .N_REQ (N_REQ),
        .SRC_W (SRC_W)
    ) u_picker (
        .i_req (bus.i_req_valid),
        .i_ptr (rr_ptr_q),
        .o_gnt (pick_gnt),
        .o_idx (pick_idx)
    );

    // A write already sitting in the output register consumes the last free
    // slot when afull is up, so space must account for it.
    assign any_req       = |bus.i_req_valid;
    assign space         = !bus.i_fifo_full && !(wr_en_q && bus.i_fifo_afull);
    assign gnt_valid     = |(bus.i_req_valid & grant_q);
    assign accept        = (state_q == BURST) && gnt_valid && space;
    assign last_beat     = accept && (beat_cnt_q == CNT_LAST);
    assign release_burst = (state_q == BURST) && (!gnt_valid || last_beat);
    assign beat_data     = bus.i_req_data[int'(gnt_idx_q) * WIDTH +: WIDTH];

    // State register.
    always_ff @(posedge i_wr_clk or negedge i_wr_rstn) begin
        if (!i_wr_rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: grant on any request, release on last beat or owner dropping valid.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req)       state_d = BURST;
            BURST:   if (release_burst) state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
    end

    // Outputs decoded from state; non-owners always see ready low.
    always_comb begin
        req_ready = '0;
        busy      = 1'b0;
        if (state_q == BURST) begin
            req_ready = grant_q & {N_REQ{space}};
            busy      = 1'b1;
        end
    end

    // Next values for grant, pointer, beat counter and the write register.
    always_comb begin
        grant_d    = grant_q;
        gnt_idx_d  = gnt_idx_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        wr_en_d    = accept;
        wr_data_d  = wr_data_q;
        wr_src_d   = wr_src_q;
        if ((state_q == IDLE) && any_req) begin
            grant_d    = pick_gnt;
            gnt_idx_d  = pick_idx;
            beat_cnt_d = '0;
        end
        if (accept) begin
            wr_data_d  = beat_data;
            wr_src_d   = gnt_idx_q;
            beat_cnt_d = beat_cnt_q + 1'b1;
        end
        if (release_burst) begin
            grant_d    = '0;
            beat_cnt_d = '0;
            rr_ptr_d   = (gnt_idx_q == IDX_LAST) ? '0 : gnt_idx_q + 1'b1;
        end
    end

    // Datapath registers; reset also discards a beat still waiting to be written.
    always_ff @(posedge i_wr_clk or negedge i_wr_rstn) begin
        if (!i_wr_rstn) begin
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
            grant_q    <= '0;
            gnt_idx_q  <= '0;
            wr_en_q    <= 1'b0;
            wr_data_q  <= '0;
            wr_src_q   <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
            grant_q    <= grant_d;
            gnt_idx_q  <= gnt_idx_d;
            wr_en_q    <= wr_en_d;
            wr_data_q  <= wr_data_d;
            wr_src_q   <= wr_src_d;
        end
    end

    assign bus.o_req_ready    = req_ready;
    assign bus.o_busy         = busy;
    assign bus.o_grant        = grant_q;
    assign bus.o_fifo_wr_en   = wr_en_q;
    assign bus.o_fifo_wr_data = wr_data_q;
    assign bus.o_fifo_wr_src  = wr_src_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: producers push beats, expected data per
// requester (and, for directed cases, the expected source order) is queued at
// issue time; a monitor pops and compares on every FIFO write.
module tb_fifo_wr_arbiter;
    import fifo_arb_pkg::*;

    localparam int N     = 4;
    localparam int W     = 8;
    localparam int BM    = 4;
    localparam int DEPTH = 6;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fifo_wr_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus ();

    fifo_wr_arbiter #(
        .N_REQ     (N),
        .WIDTH     (W),
        .BURST_MAX (BM)
    ) dut (
        .i_wr_clk  (clk),
        .i_wr_rstn (rst_n),
        .bus       (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [W-1:0] src_q [N][$];
    logic [W-1:0] exp_q [N][$];
    int           exp_src_q [$];
    logic [5:0]   seq [N];
    logic [N-1:0] en    = '0;
    logic [N-1:0] fire  = '0;
    logic drain       = 1'b1;
    logic force_full  = 1'b0;
    logic force_afull = 1'b0;
    logic stress      = 1'b0;
    int   occ;

    int t1_busy [9] = '{1, 1, 1, 1, 0, 1, 1, 1, 0};
    int t1_wr   [9] = '{0, 1, 1, 1, 1, 0, 1, 1, 0};

    // Small FIFO occupancy model producing the full/almost-full flags.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) occ <= 0;
        else        occ <= occ + (bus.o_fifo_wr_en ? 1 : 0) - ((drain && occ > 0) ? 1 : 0);
    end
    assign bus.i_fifo_full  = force_full  || (occ >= DEPTH);
    assign bus.i_fifo_afull = force_afull || (occ >= DEPTH - 1);

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
        end
    endtask

    function automatic int pending();
        int s = exp_src_q.size();
        for (int k = 0; k < N; k++) s += src_q[k].size() + exp_q[k].size();
        return s;
    endfunction

    task automatic refresh();
        for (int k = 0; k < N; k++) begin
            bus.i_req_valid[k]       = en[k] && (src_q[k].size() > 0);
            bus.i_req_data[k*W +: W] = (src_q[k].size() > 0) ? src_q[k][0] : '0;
        end
    endtask

    task automatic push_beat(input int k);
        logic [1:0]   kk = 2'(k);
        logic [W-1:0] d  = {kk, seq[k]};
        seq[k] = seq[k] + 6'd1;
        src_q[k].push_back(d);
        exp_q[k].push_back(d);
    endtask

    task automatic push_n(input int k, input int n);
        for (int i = 0; i < n; i++) push_beat(k);
    endtask

    task automatic expect_order(input int k, input int n);
        for (int i = 0; i < n; i++) exp_src_q.push_back(k);
    endtask

    task automatic clear_all();
        for (int k = 0; k < N; k++) begin
            src_q[k].delete();
            exp_q[k].delete();
        end
        exp_src_q.delete();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_wr_en"},   int'(bus.o_fifo_wr_en),   0);
        chk({tag, "_wr_data"}, int'(bus.o_fifo_wr_data), 0);
        chk({tag, "_wr_src"},  int'(bus.o_fifo_wr_src),  0);
        chk({tag, "_grant"},   int'(bus.o_grant),        0);
        chk({tag, "_busy"},    int'(bus.o_busy),         0);
        chk({tag, "_ready"},   int'(bus.o_req_ready),    0);
    endtask

    task automatic wait_drained(input string tag, input int budget);
        int n = 0;
        while (pending() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk({tag, "_left_undrained"}, pending(), 0);
        repeat (4) @(posedge clk);
        #2;
    endtask

    // Producer side: handshake sampled mid-cycle, queues advanced after the edge.
    task automatic driver();
        forever begin
            @(negedge clk);
            fire = bus.i_req_valid & bus.o_req_ready;
            @(posedge clk);
            #1;
            for (int k = 0; k < N; k++)
                if (fire[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
            if (stress) begin
                for (int k = 0; k < N; k++) begin
                    if (src_q[k].size() < 3) push_beat(k);
                    en[k] = ($urandom_range(0, 3) != 0);
                end
                drain = 1'($urandom_range(0, 1));
            end
            refresh();
        end
    endtask

    task automatic monitor();
        logic [W-1:0] e;
        int s;
        forever begin
            @(negedge clk);
            if (rst_n && bus.o_fifo_wr_en) begin
                s = int'(bus.o_fifo_wr_src);
                chk("write_while_full", int'(bus.i_fifo_full), 0);
                if (exp_q[s].size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write src=%0d data=%0h required=none", s, bus.o_fifo_wr_data);
                end else begin
                    e = exp_q[s].pop_front();
                    chk($sformatf("wr_data_src%0d", s), int'(bus.o_fifo_wr_data), int'(e));
                end
                if (exp_src_q.size() > 0) chk("wr_src_order", s, exp_src_q.pop_front());
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < N; k++) seq[k] = '0;
        bus.i_req_valid = '0;
        bus.i_req_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset_held");
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        chk_zero("reset_released");
        fork
            driver();
            monitor();
        join_none
        @(posedge clk);
        #2;

        // Requester 0 alone, 6 beats: 4-beat burst, one IDLE cycle, 2-beat burst.
        push_n(0, 6);
        expect_order(0, 6);
        en = 4'b0001;
        refresh();
        for (int i = 0; i < 9; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("t1_busy_c%0d", i), int'(bus.o_busy), t1_busy[i]);
            chk($sformatf("t1_wr_en_c%0d", i), int'(bus.o_fifo_wr_en), t1_wr[i]);
            if (i == 0) chk("t1_first_grant", int'(bus.o_grant), 1);
            if (i == 4) chk("t1_grant_idle", int'(bus.o_grant), 0);
        end
        wait_drained("t1", 100);

        // rr_ptr now 1: with 0 and 1 both requesting, 1 goes first.
        push_n(0, 4);
        push_n(1, 4);
        expect_order(1, 4);
        expect_order(0, 4);
        en = 4'b0011;
        refresh();
        wait_drained("t2", 200);

        // Reset mid-burst with beat_cnt == 2; the in-flight beat is discarded.
        push_n(3, 8);
        expect_order(3, 1);
        en = 4'b1000;
        refresh();
        repeat (3) @(posedge clk);
        #2;
        chk("t3_inflight_wr_en", int'(bus.o_fifo_wr_en), 1);
        chk("t3_inflight_grant", int'(bus.o_grant), 8);
        #1;
        rst_n = 1'b0;
        #1;
        chk_zero("t3_async_reset");
        clear_all();
        refresh();
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        // rr_ptr back to 0, so 0 wins over 3.
        push_n(0, 4);
        push_n(3, 4);
        expect_order(0, 4);
        expect_order(3, 4);
        en = 4'b1001;
        refresh();
        wait_drained("t3", 200);

        // All four continuously: 0,1,2,3,0 with 4 beats each.
        push_n(0, 8);
        push_n(1, 4);
        push_n(2, 4);
        push_n(3, 4);
        expect_order(0, 4);
        expect_order(1, 4);
        expect_order(2, 4);
        expect_order(3, 4);
        expect_order(0, 4);
        en = 4'b1111;
        refresh();
        wait_drained("t4", 400);

        // rr_ptr=1: 2 drops after 2 beats -> rr_ptr=3, then 3, then 0.
        push_n(2, 2);
        push_n(3, 2);
        push_n(0, 2);
        expect_order(2, 2);
        expect_order(3, 2);
        expect_order(0, 2);
        refresh();
        wait_drained("t5", 200);

        // Almost-full with a write in flight, then a 5-cycle full stall.
        push_n(1, 6);
        expect_order(1, 6);
        en = 4'b0010;
        refresh();
        @(posedge clk);
        @(negedge clk);
        chk("t6_ready_granted", int'(bus.o_req_ready), 2);
        @(posedge clk);
        #2;
        force_afull = 1'b1;
        @(negedge clk);
        chk("t6_afull_inflight_wr_en", int'(bus.o_fifo_wr_en), 1);
        chk("t6_afull_ready", int'(bus.o_req_ready), 0);
        @(posedge clk);
        #2;
        force_afull = 1'b0;
        force_full  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("t6_full_wr_en_c%0d", i), int'(bus.o_fifo_wr_en), 0);
            chk($sformatf("t6_full_grant_c%0d", i), int'(bus.o_grant), 2);
            chk($sformatf("t6_full_ready_c%0d", i), int'(bus.o_req_ready), 0);
            @(posedge clk);
        end
        #2;
        force_full = 1'b0;
        wait_drained("t6", 200);

        // Random valid and drain stress.
        stress = 1'b1;
        repeat (10000) @(posedge clk);
        #2;
        stress = 1'b0;
        en     = '1;
        drain  = 1'b1;
        refresh();
        wait_drained("stress", 2000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
